hc595_frame_decoder: RTL and testbench

- Receiver end of the 74HC595 serial display link (rclk/sclk/sdio) that the segment driver transmits on.
- Oversamples the three link lines in the system clock domain and shifts in 16-bit frames. On each latch strobe it decodes the frame into a per-digit display image: 5-bit digit code plus dot per position.
- Used as an on-board or bench monitor so the calculator's displayed value can be read back and checked without the physical display.

---
 rtl/hc595_frame_decoder_if.sv | 27 ++
 rtl/hc595_frame_decoder.sv | 197 +++++++++++++++++++
 tb/tb_hc595_frame_decoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hc595_frame_decoder_if.sv
// Link and display-image bundle for the 74HC595 frame decoder.
// The master side drives the serial link and clear; the slave side is the decoder.
interface hc595_frame_decoder_if;
  logic        rclk_in;
  logic        sclk_in;
  logic        sdio_in;
  logic        clear;
  logic [39:0] digit_codes;
  logic [7:0]  dot_en;
  logic [7:0]  valid_mask;
  logic        frame_valid;
  logic        frame_err;
  logic        sel_err;
  logic        pattern_err;

  modport master (
    output rclk_in, sclk_in, sdio_in, clear,
    input  digit_codes, dot_en, valid_mask,
    input  frame_valid, frame_err, sel_err, pattern_err
  );

  modport slave (
    input  rclk_in, sclk_in, sdio_in, clear,
    output digit_codes, dot_en, valid_mask,
    output frame_valid, frame_err, sel_err, pattern_err
  );
endinterface

// File: rtl/hc595_frame_decoder.sv
// Oversampling receiver for the 74HC595 display link; rebuilds the per-digit
// display image (code + dot) from latched 16-bit frames.
module hc595_frame_decoder #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FRAME_BITS   = 16,
  parameter logic [4:0]  CODE_UNKNOWN = 5'd31
) (
  input  logic                   clk,
  input  logic                   rst,
  hc595_frame_decoder_if.slave   link
);

  localparam int unsigned CNT_W    = 5;
  localparam int unsigned N_POS    = 8;
  localparam int unsigned CODE_W   = 5;
  localparam int unsigned LINK_W   = 3;
  localparam int unsigned SEL_CW   = 4;
  localparam int unsigned POS_W    = 3;
  localparam logic [CNT_W-1:0]  CNT_MAX    = 5'd31;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'd16;

  // Link bit positions inside the synchroniser vector.
  localparam int unsigned L_SDIO = 0;
  localparam int unsigned L_SCLK = 1;
  localparam int unsigned L_RCLK = 2;

  logic [SYNC_STAGES-1:0][LINK_W-1:0] sync_q, sync_d;
  logic [1:0]                         prev_q, prev_d;
  logic [FRAME_BITS-1:0]              shreg_q, shreg_d;
  logic [CNT_W-1:0]                   bitcnt_q, bitcnt_d;

  logic                               lat_q, lat_d;
  logic [FRAME_BITS-1:0]              lat_frame_q, lat_frame_d;
  logic                               lat_cnt_ok_q, lat_cnt_ok_d;

  logic [N_POS-1:0][CODE_W-1:0]       codes_q, codes_d;
  logic [N_POS-1:0]                   dot_q, dot_d;
  logic [N_POS-1:0]                   valid_q, valid_d;
  logic                               fv_q, fv_d;
  logic                               fe_q, fe_d;
  logic                               se_q, se_d;
  logic                               pe_q, pe_d;

  logic [LINK_W-1:0]                  sync_out_c;
  logic                               sclk_rise_c;
  logic                               rclk_rise_c;
  logic                               sdio_c;
  logic [7:0]                         pat_c;
  logic [CODE_W-1:0]                  code_c;
  logic                               unknown_c;
  logic [SEL_CW-1:0]                  zero_cnt_c;
  logic [POS_W-1:0]                   sel_pos_c;

  // Synchroniser chain and edge detection on the link lines.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {link.rclk_in, link.sclk_in, link.sdio_in};
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sync_out_c  = sync_q[SYNC_STAGES-1];
    prev_d      = {sync_out_c[L_RCLK], sync_out_c[L_SCLK]};
    sclk_rise_c = sync_out_c[L_SCLK] & ~prev_q[0];
    rclk_rise_c = sync_out_c[L_RCLK] & ~prev_q[1];
    sdio_c      = sync_out_c[L_SDIO];
  end

  // Shift register and saturating bit counter; a latch restarts the count,
  // with a coincident shift counting toward the next frame.
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (sclk_rise_c) begin
      shreg_d = {shreg_q[FRAME_BITS-2:0], sdio_c};
    end
    if (rclk_rise_c) begin
      bitcnt_d = sclk_rise_c ? CNT_W'(1) : '0;
    end else if (sclk_rise_c && (bitcnt_q != CNT_MAX)) begin
      bitcnt_d = bitcnt_q + CNT_W'(1);
    end
  end

  // Latch snapshot: pre-shift frame contents, like the 595 storage register.
  always_comb begin
    lat_d        = rclk_rise_c;
    lat_frame_d  = lat_frame_q;
    lat_cnt_ok_d = lat_cnt_ok_q;
    if (rclk_rise_c) begin
      lat_frame_d  = shreg_q;
      lat_cnt_ok_d = (bitcnt_q == CNT_W'(FRAME_BITS));
    end
  end

  // Digit select analysis: exactly one active-low bit is a legal select.
  always_comb begin
    zero_cnt_c = '0;
    sel_pos_c  = '0;
    for (int i = 0; i < int'(N_POS); i++) begin
      if (!lat_frame_q[i]) begin
        zero_cnt_c = zero_cnt_c + SEL_CW'(1);
        sel_pos_c  = POS_W'(i);
      end
    end
  end

  // Segment pattern decode with the dot forced off.
  always_comb begin
    pat_c     = lat_frame_q[FRAME_BITS-1 -: 8] | 8'h80;
    code_c    = CODE_UNKNOWN;
    unknown_c = 1'b0;
    case (pat_c)
      8'hC0:   code_c = 5'd0;
      8'hF9:   code_c = 5'd1;
      8'hA4:   code_c = 5'd2;
      8'hB0:   code_c = 5'd3;
      8'h99:   code_c = 5'd4;
      8'h92:   code_c = 5'd5;
      8'h82:   code_c = 5'd6;
      8'hF8:   code_c = 5'd7;
      8'h80:   code_c = 5'd8;
      8'h90:   code_c = 5'd9;
      8'hBF:   code_c = 5'd12;
      8'hFF:   code_c = 5'd16;
      default: begin
        code_c    = CODE_UNKNOWN;
        unknown_c = 1'b1;
      end
    endcase
  end

  // Apply a latched frame to the display image and raise the status pulses.
  always_comb begin
    codes_d = codes_q;
    dot_d   = dot_q;
    valid_d = valid_q;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    se_d    = 1'b0;
    pe_d    = 1'b0;
    if (lat_q) begin
      if (!lat_cnt_ok_q) begin
        fe_d = 1'b1;
      end else if (zero_cnt_c != SEL_CW'(1)) begin
        se_d = 1'b1;
      end else begin
        codes_d[sel_pos_c] = code_c;
        dot_d[sel_pos_c]   = ~lat_frame_q[FRAME_BITS-1];
        valid_d[sel_pos_c] = 1'b1;
        fv_d               = 1'b1;
        pe_d               = unknown_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || link.clear) begin
      sync_q       <= '0;
      prev_q       <= '0;
      shreg_q      <= '1;
      bitcnt_q     <= '0;
      lat_q        <= 1'b0;
      lat_frame_q  <= '1;
      lat_cnt_ok_q <= 1'b0;
      codes_q      <= {N_POS{CODE_BLANK}};
      dot_q        <= '0;
      valid_q      <= '0;
      fv_q         <= 1'b0;
      fe_q         <= 1'b0;
      se_q         <= 1'b0;
      pe_q         <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      lat_q        <= lat_d;
      lat_frame_q  <= lat_frame_d;
      lat_cnt_ok_q <= lat_cnt_ok_d;
      codes_q      <= codes_d;
      dot_q        <= dot_d;
      valid_q      <= valid_d;
      fv_q         <= fv_d;
      fe_q         <= fe_d;
      se_q         <= se_d;
      pe_q         <= pe_d;
    end
  end

  assign link.digit_codes = codes_q;
  assign link.dot_en      = dot_q;
  assign link.valid_mask  = valid_q;
  assign link.frame_valid = fv_q;
  assign link.frame_err   = fe_q;
  assign link.sel_err     = se_q;
  assign link.pattern_err = pe_q;

endmodule

// File: tb/tb_hc595_frame_decoder.sv
// Directed plus randomized bench for hc595_frame_decoder against a frame-level
// model built from a queue of shifted bits and a pattern lookup table.
module tb_hc595_frame_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hc595_frame_decoder_if link();

  hc595_frame_decoder #(
    .SYNC_STAGES  (2),
    .FRAME_BITS   (16),
    .CODE_UNKNOWN (5'd31)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit         bits_q[$];
  int         m_code[8];
  logic [7:0] m_dot;
  logic [7:0] m_valid;
  logic [7:0] pat_tab[12]  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                               8'h82, 8'hF8, 8'h80, 8'h90, 8'hBF, 8'hFF};
  int         code_tab[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 16};

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] m_vec();
    logic [39:0] v;
    for (int p = 0; p < 8; p++) v[5*p +: 5] = 5'(m_code[p]);
    return v;
  endfunction

  task automatic model_reset();
    bits_q.delete();
    for (int p = 0; p < 8; p++) m_code[p] = 16;
    m_dot   = '0;
    m_valid = '0;
  endtask

  // Evaluate a latch from the bits shifted since the previous latch.
  task automatic model_latch(output bit efv, output bit efe, output bit ese, output bit epe);
    logic [15:0] f;
    int zeros, pos, code;
    bit known;
    efv = 0; efe = 0; ese = 0; epe = 0;
    if (bits_q.size() != 16) begin
      efe = 1;
    end else begin
      f = '0;
      foreach (bits_q[i]) f = {f[14:0], bits_q[i]};
      zeros = 0; pos = 0;
      for (int i = 0; i < 8; i++) if (f[i] == 1'b0) begin zeros++; pos = i; end
      if (zeros != 1) begin
        ese = 1;
      end else begin
        known = 0; code = 31;
        for (int k = 0; k < 12; k++)
          if ((f[15:8] | 8'h80) == pat_tab[k]) begin known = 1; code = code_tab[k]; end
        m_code[pos]  = code;
        m_dot[pos]   = ~f[15];
        m_valid[pos] = 1'b1;
        efv = 1;
        epe = !known;
      end
    end
    bits_q.delete();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input bit b);
    link.sdio_in = b;
    cyc(4);
    link.sclk_in = 1'b1;
    bits_q.push_back(b);
    cyc(4);
    link.sclk_in = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic check_image(input string tag);
    chk({tag, ".codes"}, link.digit_codes, m_vec());
    chk({tag, ".dot"},   40'(link.dot_en), 40'(m_dot));
    chk({tag, ".valid"}, 40'(link.valid_mask), 40'(m_valid));
  endtask

  // Raise rclk (optionally with a coincident shift of bit b) and check pulses.
  task automatic latch(input string tag, input bit with_shift, input bit b);
    bit efv, efe, ese, epe;
    int cv, ce, cs, cp, first;
    if (with_shift) begin
      link.sdio_in = b;
      cyc(4);
    end
    model_latch(efv, efe, ese, epe);
    link.rclk_in = 1'b1;
    if (with_shift) begin
      link.sclk_in = 1'b1;
      bits_q.push_back(b);
    end
    cv = 0; ce = 0; cs = 0; cp = 0; first = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (link.frame_valid) cv++;
      if (link.frame_err)   ce++;
      if (link.sel_err)     cs++;
      if (link.pattern_err && link.frame_valid) cp++;
      if (link.pattern_err && !link.frame_valid) cp += 16;
      if ((link.frame_valid || link.frame_err || link.sel_err) && first == 0) first = i;
    end
    chk({tag, ".pulses"}, {8'(cv), 8'(ce), 8'(cs), 8'(cp), 8'd0},
                          {8'(efv), 8'(efe), 8'(ese), 8'(epe), 8'd0});
    chk({tag, ".latency"}, 40'(first), 40'd4);
    link.rclk_in = 1'b0;
    link.sclk_in = 1'b0;
    cyc(4);
    check_image(tag);
  endtask

  initial begin
    int kind, pos, pi, len;
    logic [7:0]  pat;
    logic [15:0] fr;
    logic [31:0] rv;

    rst = 1'b1;
    link.rclk_in = 1'b0;
    link.sclk_in = 1'b0;
    link.sdio_in = 1'b0;
    link.clear   = 1'b0;
    model_reset();
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check_image("reset");
    chk("reset.pulses", 40'({link.frame_valid, link.frame_err, link.sel_err, link.pattern_err}), 40'd0);

    // Directed frames.
    send(32'hA4FB, 16); latch("d2_pos2", 0, 0);
    send(32'h40FE, 16); latch("d0dp_pos0", 0, 0);
    send(32'h7FFF, 15); latch("short15", 0, 0);
    send(32'h1F9FE, 17); latch("long17", 0, 0);
    send(32'hF9FC, 16); latch("two_sel", 0, 0);
    send(32'h8D7F, 16); latch("unk_pos7", 0, 0);

    // Digits 1..8 across all positions, then clear.
    for (int p = 0; p < 8; p++) begin
      fr = {pat_tab[p + 1], ~(8'h01 << p)};
      send(32'(fr), 16);
      latch("sweep", 0, 0);
    end
    link.clear = 1'b1;
    cyc(1);
    link.clear = 1'b0;
    model_reset();
    check_image("clear");

    // Reset mid-frame, then a short latch and a good frame.
    send(32'hB0, 8);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    model_reset();
    check_image("rst_mid");
    send(32'hFF, 8); latch("rst_short", 0, 0);
    send(32'hB0F7, 16); latch("rst_good", 0, 0);

    // Coincident sclk/rclk: pre-shift frame latched, shifted bit starts next frame.
    send(32'h99DF, 16); latch("simul", 1, 1);
    send(32'h7F7F, 15); latch("simul_next", 0, 0);

    // Randomized frames.
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 9));
      rv   = $urandom;
      if (kind == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 15 : 17;
        send(rv, len);
      end else if (kind == 1) begin
        send(32'(rv[15:0]), 16);
      end else begin
        pos = int'($urandom_range(0, 7));
        pi  = int'($urandom_range(0, 11));
        pat = ($urandom_range(0, 4) == 0) ? rv[7:0] : pat_tab[pi];
        pat[7] = rv[8];
        fr  = {pat, ~(8'h01 << pos)};
        send(32'(fr), 16);
      end
      latch("rand", ($urandom_range(0, 5) == 0), rv[9]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
